// File: rtl/iomem_router.sv
// iomem_router: routes a single host iomem transaction to one of four slaves,
// an internal status register, or an unmapped sink. Slave accesses that do
// not complete within TIMEOUT cycles are force-completed with all-ones data
// and logged in the status register.
module iomem_router #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         iomem_valid,
  input  logic [3:0]   iomem_wstrb,
  input  logic [31:0]  iomem_addr,
  input  logic [31:0]  iomem_wdata,
  output logic         iomem_ready,
  output logic [31:0]  iomem_rdata,
  output logic [3:0]   s_valid,
  output logic [23:0]  s_addr,
  output logic [3:0]   s_wstrb,
  output logic [31:0]  s_wdata,
  input  logic [3:0]   s_ready,
  input  logic [127:0] s_rdata
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  sel;
  logic [15:0] cnt;
  logic [15:0] to_cnt;
  logic        unm_sticky;
  logic        to_sticky;
  logic [1:0]  to_idx;

  logic [7:0]  region;
  logic        is_slave;
  logic        is_status;
  logic [1:0]  dec_sel;
  logic [31:0] status_word;
  logic [31:0] sel_rdata;
  logic        sel_ready;

  assign s_addr  = iomem_addr[23:0];
  assign s_wstrb = iomem_wstrb;
  assign s_wdata = iomem_wdata;
  assign region  = iomem_addr[31:24];

  // Region decode, selected-slave response mux and status word assembly.
  always_comb begin
    is_slave    = (region >= 8'h03) && (region <= 8'h06);
    is_status   = (region == 8'h07);
    // Regions 0x03..0x06 map to 0..3: low two bits plus one, modulo 4.
    dec_sel     = region[1:0] + 2'd1;
    sel_rdata   = s_rdata[{sel, 5'b00000} +: 32];
    sel_ready   = s_ready[sel];
    status_word = {to_cnt, 8'h00, unm_sticky, to_sticky, 4'h0, to_idx};
  end

  // Transaction FSM with registered host/slave handshake and status logging.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      sel         <= '0;
      cnt         <= '0;
      to_cnt      <= '0;
      unm_sticky  <= 1'b0;
      to_sticky   <= 1'b0;
      to_idx      <= '0;
      s_valid     <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          iomem_ready <= 1'b0;
          if (iomem_valid) begin
            if (is_slave) begin
              sel     <= dec_sel;
              cnt     <= '0;
              s_valid <= 4'b0001 << dec_sel;
              state   <= ACTIVE;
            end else if (is_status) begin
              if (iomem_wstrb != 4'h0) begin
                if (iomem_wstrb[0] && iomem_wdata[0]) begin
                  to_cnt     <= '0;
                  unm_sticky <= 1'b0;
                  to_sticky  <= 1'b0;
                  to_idx     <= '0;
                end
                iomem_rdata <= '0;
              end else begin
                iomem_rdata <= status_word;
              end
              iomem_ready <= 1'b1;
              state       <= RESP;
            end else begin
              iomem_rdata <= '0;
              unm_sticky  <= 1'b1;
              iomem_ready <= 1'b1;
              state       <= RESP;
            end
          end
        end
        ACTIVE: begin
          // A slave answer in the expiry cycle takes priority over the timeout.
          if (sel_ready) begin
            iomem_rdata <= sel_rdata;
            s_valid     <= '0;
            iomem_ready <= 1'b1;
            state       <= RESP;
          end else if (cnt == TO_LAST) begin
            iomem_rdata <= '1;
            s_valid     <= '0;
            iomem_ready <= 1'b1;
            state       <= RESP;
            to_sticky   <= 1'b1;
            to_idx      <= sel;
            if (to_cnt != 16'hFFFF) begin
              to_cnt <= to_cnt + 16'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          iomem_ready <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_router.sv
// Scoreboard bench for iomem_router: the driver predicts each response from
// a behavioural model and queues it; an independent monitor checks every
// iomem_ready pulse against the queue head (data and latency).
module tb_iomem_router;

  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         iomem_valid = 1'b0;
  logic [3:0]   iomem_wstrb = '0;
  logic [31:0]  iomem_addr = '0;
  logic [31:0]  iomem_wdata = '0;
  logic         iomem_ready;
  logic [31:0]  iomem_rdata;
  logic [3:0]   s_valid;
  logic [23:0]  s_addr;
  logic [3:0]   s_wstrb;
  logic [31:0]  s_wdata;
  logic [3:0]   s_ready = '0;
  logic [127:0] s_rdata = '0;

  iomem_router #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_ready(iomem_ready), .iomem_rdata(iomem_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rdata;
    int          issue;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  // Behavioural status model.
  int       m_cnt = 0;
  bit       m_unm = 1'b0;
  bit       m_to  = 1'b0;
  int       m_idx = 0;

  function automatic logic [31:0] m_status();
    return (32'(m_cnt) << 16) | (m_unm ? 32'h80 : 32'h0) |
           (m_to ? 32'h40 : 32'h0) | 32'(m_idx);
  endfunction

  task automatic m_clear();
    m_cnt = 0; m_unm = 1'b0; m_to = 1'b0; m_idx = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (iomem_ready === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("ready_without_request", {31'b0, iomem_ready}, 32'h0);
        end else begin
          e = sbq.pop_front();
          chk("rdata", iomem_rdata, e.rdata);
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
        end
      end
    end
  end

  // One host transaction. j: ACTIVE cycle in which the slave answers
  // (0 = silent); rst_at: ACTIVE cycle at which reset is pulsed for 2 cycles
  // (0 = none); hammer: assert every non-selected s_ready bit throughout.
  task automatic txn(input logic [7:0] region, input logic [23:0] off,
                     input logic [3:0] wstrb, input logic [31:0] wdata,
                     input logic [31:0] resp, input int j, input int rst_at,
                     input bit hammer);
    exp_t e;
    bit   slave;
    int   sel;
    bit   dropped;
    slave   = (region >= 8'h03) && (region <= 8'h06);
    sel     = int'(region) - 3;
    dropped = 1'b0;
    e.issue = cyc;
    if (slave) begin
      if (j >= 1 && j <= int'(TO)) begin
        e.rdata = resp;
        e.lat   = 1 + j;
      end else begin
        e.rdata = 32'hFFFF_FFFF;
        e.lat   = 1 + int'(TO);
        if (m_cnt < 65535) m_cnt++;
        m_to  = 1'b1;
        m_idx = sel;
      end
    end else if (region == 8'h07) begin
      e.lat = 1;
      if (wstrb == 4'h0) begin
        e.rdata = m_status();
      end else begin
        e.rdata = 32'h0;
        if (wstrb[0] && wdata[0]) m_clear();
      end
    end else begin
      e.lat   = 1;
      e.rdata = 32'h0;
      m_unm   = 1'b1;
    end
    if (rst_at == 0) sbq.push_back(e);

    iomem_valid = 1'b1;
    iomem_addr  = {region, off};
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    @(posedge clk); #1;
    chk("s_addr", {8'h0, s_addr}, {8'h0, off});

    if (slave) begin
      for (int k = 1; k <= int'(TO); k++) begin
        chk("s_valid_active", {28'h0, s_valid}, 32'h1 << sel);
        if (k == rst_at) begin
          resetn      = 1'b0;
          iomem_valid = 1'b0;
          s_ready     = '0;
          for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            chk("rst_s_valid", {28'h0, s_valid}, 32'h0);
            chk("rst_ready", {31'h0, iomem_ready}, 32'h0);
            chk("rst_rdata", iomem_rdata, 32'h0);
          end
          resetn = 1'b1;
          m_clear();
          return;
        end
        s_ready = hammer ? (4'hF & ~(4'h1 << sel)) : (4'($urandom) & ~(4'h1 << sel));
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (k == j) begin
          s_ready[sel]           = 1'b1;
          s_rdata[sel*32 +: 32]  = resp;
        end
        if (k > 1 && !dropped && ($urandom_range(0, 1) == 1)) begin
          iomem_valid = 1'b0;
          dropped     = 1'b1;
        end
        @(posedge clk); #1;
        if (k == j) break;
      end
      chk("s_valid_resp", {28'h0, s_valid}, 32'h0);
    end else begin
      chk("s_valid_none", {28'h0, s_valid}, 32'h0);
    end
    iomem_valid = 1'b0;
    s_ready     = 4'($urandom);
    @(posedge clk); #1;
    for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
      s_ready = 4'($urandom);
      @(posedge clk); #1;
    end
    s_ready = '0;
  endtask

  initial begin
    logic [7:0] rg;
    int         kind;
    int         jj;

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'h0, iomem_ready}, 32'h0);
    chk("reset_s_valid", {28'h0, s_valid}, 32'h0);
    chk("reset_rdata", iomem_rdata, 32'h0);
    resetn = 1'b1;

    // Slave 1 answers in its third ACTIVE cycle; issued right after reset.
    txn(8'h04, 24'h000010, 4'h0, 32'h0, 32'h1234_5678, 3, 0, 1'b0);
    // Slave 2 silent: timeout, then status reflects it.
    txn(8'h05, 24'h000000, 4'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    txn(8'h07, 24'h000000, 4'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    // Unmapped write, status read, status clear, status read.
    txn(8'h09, 24'h000000, 4'hF, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
    txn(8'h07, 24'h000000, 4'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    txn(8'h07, 24'h000000, 4'h1, 32'h1, 32'h0, 0, 0, 1'b0);
    txn(8'h07, 24'h000000, 4'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    // Slave 0 answers exactly in the expiry cycle.
    txn(8'h03, 24'h000100, 4'h0, 32'h0, 32'hA5A5_0F0F, int'(TO), 0, 1'b0);
    txn(8'h07, 24'h000000, 4'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    // Create some status, then reset mid-ACTIVE; status must come back 0.
    txn(8'h0A, 24'h000000, 4'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    txn(8'h04, 24'h000020, 4'h0, 32'h0, 32'h0, 0, 2, 1'b0);
    txn(8'h07, 24'h000000, 4'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    txn(8'h06, 24'h000030, 4'h3, 32'h5555_AAAA, 32'h0BAD_F00D, 1, 0, 1'b0);
    // Slave 0 selected while all other ready bits are held high.
    txn(8'h03, 24'h000040, 4'h0, 32'h0, 32'hCAFE_0003, 4, 0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 5) begin
        jj = int'($urandom_range(1, TO + 2));
        if (jj > int'(TO)) jj = 0;
        txn(8'(3 + $urandom_range(0, 3)), 24'($urandom), 4'($urandom),
            $urandom, $urandom, jj, 0, 1'b0);
      end else if (kind <= 7) begin
        if ($urandom_range(0, 3) == 0)
          txn(8'h07, 24'($urandom), 4'h1, 32'h1, 32'h0, 0, 0, 1'b0);
        else
          txn(8'h07, 24'($urandom), 4'h0, $urandom, 32'h0, 0, 0, 1'b0);
      end else begin
        do rg = 8'($urandom); while (rg >= 8'h03 && rg <= 8'h07);
        txn(rg, 24'($urandom), 4'($urandom), $urandom, 32'h0, 0, 0, 1'b0);
      end
    end
    txn(8'h07, 24'h000000, 4'h0, 32'h0, 32'h0, 0, 0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(sbq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
